// File: rtl/ice_dcntr.sv
// Prescaled down-counter with one-shot / periodic reload.
// Borrow pulses on the terminal tick; busy and done decode the state.
module ice_dcntr #(
    parameter int PSC_WIDTH  = 21,
    parameter int CNTR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [CNTR_WIDTH-1:0] load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  auto_reload,
    output logic [CNTR_WIDTH-1:0] s,
    output logic                  b,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [PSC_WIDTH-1:0]  PSC_ONE = 1;

    state_e                state_q, state_d;
    logic [CNTR_WIDTH-1:0] s_q, s_d;
    logic [CNTR_WIDTH-1:0] reload_q, reload_d;
    logic [PSC_WIDTH-1:0]  psc_q, psc_d;
    logic                  b_q, b_d;
    logic                  tick;

    assign tick = &psc_q;

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        reload_d = reload_q;
        b_d      = 1'b0;
        psc_d    = psc_q + PSC_ONE;
        unique case (state_q)
            IDLE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (load) begin
                    s_d      = load_val;
                    reload_d = load_val;
                end else if (start && s_q != '0) begin
                    state_d = RUN;
                    psc_d   = '0;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (load) begin
                    s_d      = load_val;
                    reload_d = load_val;
                    if (load_val == '0) state_d = IDLE;
                end else if (tick) begin
                    if (s_q > CNT_ONE) begin
                        s_d = s_q - CNT_ONE;
                    end else if (s_q == CNT_ONE) begin
                        b_d = 1'b1;
                        if (auto_reload && reload_q != '0) begin
                            s_d = reload_q;
                        end else begin
                            s_d     = '0;
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (load) begin
                    s_d      = load_val;
                    reload_d = load_val;
                    state_d  = IDLE;
                end else if (start && reload_q != '0) begin
                    s_d     = reload_q;
                    state_d = RUN;
                    psc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            reload_q <= '0;
            psc_q    <= '0;
            b_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            reload_q <= reload_d;
            psc_q    <= psc_d;
            b_q      <= b_d;
        end
    end

    assign s    = s_q;
    assign b    = b_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_ice_dcntr.sv
// Directed bench for ice_dcntr with a 4-cycle tick.
// Each scenario task drives stimulus and checks outputs inline.
module tb_ice_dcntr;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] s;
    logic       b;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_bad;

    ice_dcntr #(
        .PSC_WIDTH (2),
        .CNTR_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .s          (s),
        .b          (b),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({s, b, busy, done} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_state: got s=%0d b=%b busy=%b done=%b want 0 0 0 0",
                     s, b, busy, done);
        end
        step(2);
        rst_n = 1'b1;
        step(3);
        n_cmp++;
        if (busy !== 1'b0 || s !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_release: got busy=%b s=%0d want 0 0", busy, s);
        end
    endtask

    task automatic test_oneshot;
        auto_reload = 1'b0;
        load = 1'b1; load_val = 4'd3;
        step(1);
        load = 1'b0;
        n_cmp++;
        if (s !== 4'd3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL os_load: got s=%0d busy=%b want 3 0", s, busy);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || s !== 4'd3) begin
            n_bad++;
            $display("FAIL os_start: got busy=%b s=%0d want 1 3", busy, s);
        end
        step(3);
        n_cmp++;
        if (s !== 4'd3) begin
            n_bad++;
            $display("FAIL os_pre_tick: got s=%0d want 3", s);
        end
        step(1);
        n_cmp++;
        if (s !== 4'd2) begin
            n_bad++;
            $display("FAIL os_t4: got s=%0d want 2", s);
        end
        step(4);
        n_cmp++;
        if (s !== 4'd1 || b !== 1'b0) begin
            n_bad++;
            $display("FAIL os_t8: got s=%0d b=%b want 1 0", s, b);
        end
        step(4);
        n_cmp++;
        if (s !== 4'd0 || b !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL os_t12: got s=%0d b=%b done=%b busy=%b want 0 1 1 0",
                     s, b, done, busy);
        end
        step(1);
        n_cmp++;
        if (b !== 1'b0 || done !== 1'b1 || s !== 4'd0) begin
            n_bad++;
            $display("FAIL os_b_width: got b=%b done=%b s=%0d want 0 1 0", b, done, s);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        n_cmp++;
        if (s !== 4'd3 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_restart: got s=%0d busy=%b done=%b want 3 1 0",
                     s, busy, done);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || s !== 4'd3) begin
            n_bad++;
            $display("FAIL os_stop: got busy=%b s=%0d want 0 3", busy, s);
        end
    endtask

    task automatic test_periodic;
        auto_reload = 1'b1;
        load = 1'b1; load_val = 4'd2;
        step(1);
        load = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(4);
        n_cmp++;
        if (s !== 4'd1 || b !== 1'b0) begin
            n_bad++;
            $display("FAIL per_t4: got s=%0d b=%b want 1 0", s, b);
        end
        step(4);
        n_cmp++;
        if (s !== 4'd2 || b !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL per_t8: got s=%0d b=%b busy=%b done=%b want 2 1 1 0",
                     s, b, busy, done);
        end
        step(1);
        n_cmp++;
        if (b !== 1'b0) begin
            n_bad++;
            $display("FAIL per_b_width: got b=%b want 0", b);
        end
        step(3);
        n_cmp++;
        if (s !== 4'd1) begin
            n_bad++;
            $display("FAIL per_t12: got s=%0d want 1", s);
        end
        step(4);
        n_cmp++;
        if (s !== 4'd2 || b !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL per_t16: got s=%0d b=%b busy=%b want 2 1 1", s, b, busy);
        end
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        auto_reload = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || s !== 4'd2) begin
            n_bad++;
            $display("FAIL per_stop: got busy=%b done=%b s=%0d want 0 0 2", busy, done, s);
        end
    endtask

    task automatic test_stop_resume;
        load = 1'b1; load_val = 4'd5;
        step(1);
        load = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        n_cmp++;
        if (s !== 4'd5 || busy !== 1'b0 || b !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_on_tick: got s=%0d busy=%b b=%b want 5 0 0", s, busy, b);
        end
        step(20);
        n_cmp++;
        if (s !== 4'd5 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_hold: got s=%0d busy=%b want 5 0", s, busy);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        n_cmp++;
        if (s !== 4'd5 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL resume_t3: got s=%0d busy=%b want 5 1", s, busy);
        end
        step(1);
        n_cmp++;
        if (s !== 4'd4) begin
            n_bad++;
            $display("FAIL resume_t4: got s=%0d want 4", s);
        end
    endtask

    task automatic test_collisions;
        step(3);
        load = 1'b1; load_val = 4'd9;
        step(1);
        load = 1'b0;
        n_cmp++;
        if (s !== 4'd9 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_vs_tick: got s=%0d busy=%b want 9 1", s, busy);
        end
        step(4);
        n_cmp++;
        if (s !== 4'd8) begin
            n_bad++;
            $display("FAIL load_no_psc_clr: got s=%0d want 8", s);
        end
        stop = 1'b1; load = 1'b1; load_val = 4'd3;
        step(1);
        stop = 1'b0; load = 1'b0;
        n_cmp++;
        if (s !== 4'd8 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_vs_load: got s=%0d busy=%b want 8 0", s, busy);
        end
        load = 1'b1; load_val = 4'd0;
        step(1);
        load = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        n_cmp++;
        if (s !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL start_zero: got s=%0d busy=%b done=%b want 0 0 0", s, busy, done);
        end
        load = 1'b1; load_val = 4'd6;
        step(1);
        load = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        load = 1'b1; load_val = 4'd0;
        step(1);
        load = 1'b0;
        n_cmp++;
        if (s !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL run_load_zero: got s=%0d busy=%b done=%b want 0 0 0",
                     s, busy, done);
        end
    endtask

    task automatic test_async_reset;
        load = 1'b1; load_val = 4'd7;
        step(1);
        load = 1'b0;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        n_cmp++;
        if (s !== 4'd7 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_pre: got s=%0d busy=%b want 7 1", s, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (s !== 4'd0 || busy !== 1'b0 || b !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL ar_async: got s=%0d busy=%b b=%b done=%b want 0 0 0 0",
                     s, busy, b, done);
        end
        step(2);
        rst_n = 1'b1;
        step(10);
        n_cmp++;
        if (s !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL ar_after: got s=%0d busy=%b done=%b want 0 0 0", s, busy, done);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        load = 1'b0;
        load_val = 4'd0;
        start = 1'b0;
        stop = 1'b0;
        auto_reload = 1'b0;
        test_reset();
        test_oneshot();
        test_periodic();
        test_stop_resume();
        test_collisions();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ice_dcntr.md
ICE_DCNTR -- requirements
Module: ice_dcntr

Interface
REQ-001 SHALL have parameter PSC_WIDTH, default 21, prescaler width; one decrement tick every 2^PSC_WIDTH clk cycles.
REQ-002 SHALL have parameter CNTR_WIDTH, default 4, width of count value s.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port load  input  1  one-cycle request to load load_val.
REQ-006 SHALL have port load_val  input  CNTR_WIDTH  value to load into s and into the reload register.
REQ-007 SHALL have port start  input  1  one-cycle request to begin counting down.
REQ-008 SHALL have port stop  input  1  one-cycle request to halt counting.
REQ-009 SHALL have port auto_reload  input  1  level; 1 = periodic mode, 0 = one-shot mode.
REQ-010 SHALL have port s  output  CNTR_WIDTH  current count, registered.
REQ-011 SHALL have port b  output  1  borrow; registered one-cycle pulse at terminal count.
REQ-012 SHALL have port busy  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  high while in DONE.

Function
REQ-014 SHALL contain a free-running PSC_WIDTH-bit prescaler; tick = 1 for one cycle when prescaler is all-ones; prescaler wraps to 0.
REQ-015 SHALL implement states IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE), both decoded from registered state.
REQ-016 Per-cycle priority SHALL be: stop > load > start > tick.
REQ-017 IDLE: load -> s<=load_val, reload<=load_val, stay IDLE.
REQ-018 IDLE: start with s!=0 -> RUN, prescaler cleared to 0 the same edge; start with s==0 SHALL be ignored.
REQ-019 RUN: tick with s>1 -> s<=s-1.
REQ-020 RUN: tick with s==1 -> b=1 for exactly one cycle; if auto_reload=1 and reload!=0, s<=reload and stay RUN; else s<=0 and go DONE.
REQ-021 RUN: stop -> IDLE, s held, b=0; tick on the same cycle SHALL have no effect.
REQ-022 RUN: load with load_val!=0 -> s<=load_val, reload<=load_val, stay RUN, prescaler not cleared; load_val==0 -> s<=0, go IDLE.
REQ-023 RUN: start SHALL be ignored.
REQ-024 DONE: start with reload!=0 -> s<=reload, RUN, prescaler cleared; load -> s<=load_val, reload<=load_val, IDLE; stop -> IDLE.
REQ-025 b SHALL be 0 in every cycle other than REQ-020; s SHALL never wrap below 0.
REQ-026 Prescaler SHALL run in all states; only tick in RUN affects s.

Reset
REQ-027 rst_n low SHALL immediately, without a clk edge, force state=IDLE, s=0, reload=0, prescaler=0, b=0, busy=0, done=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the count; after release the block SHALL remain IDLE until load/start.
REQ-029 Release of rst_n SHALL take effect at the next rising clk edge; no tick earlier than 2^PSC_WIDTH cycles after release.

Verification (PSC_WIDTH=2, CNTR_WIDTH=4: tick every 4 cycles)
REQ-030 One-shot: load 3, start, auto_reload=0 -> s 3,2,1,0 at 4, 8, 12 cycles after start; b high 1 cycle with s=0; done=1, busy=0.
REQ-031 Periodic: load 2, auto_reload=1, start -> s 2,1,2,1,...; b pulses every 8 cycles; busy stays 1, done stays 0.
REQ-032 Stop/resume: stop when s=5 -> IDLE, s=5 held 20 cycles; start -> s=4 exactly 4 cycles later.
REQ-033 Collisions: load 9 coincident with tick in RUN -> s=9; stop+load same cycle -> IDLE, s unchanged; start with s=0 in IDLE -> stays IDLE.
REQ-034 Async reset: drop rst_n mid-cycle in RUN with s=7 -> s=0, busy=0, b=0 before next clk edge; stays IDLE after release.
